ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Round-robin arbiter that shares one port of the dual-port synchronous RAM between four requesters.
- Converts each requester's req/ack transaction into the RAM's cs/we/oe/address/bidirectional-data protocol.
- Sits between client logic and one RAM port; a second instance, or a direct client, may own the other port.
- The bidirectional data pin is resolved one level up from ram_data_out, ram_data_drive and ram_data_in.

Parameters:
- DATA_WIDTH, 8, RAM word width.
- ADDR_WIDTH, 8, RAM address width.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  4  per-requester transaction request; held high until ack.
- req_we  input  4  per-requester op: 1 = write, 0 = read; stable while req is high.
- req_addr  input  4*ADDR_WIDTH  packed addresses; requester i owns bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  input  4*DATA_WIDTH  packed write data; requester i owns bits [i*DATA_WIDTH +: DATA_WIDTH].
- ack  output  4  one-hot, one-cycle completion strobe.
- rdata  output  DATA_WIDTH  read data; valid only while ack[i] is high and the op is a read.
- busy  output  1  high in any state other than IDLE.
- ram_cs  output  1  RAM chip select.
- ram_we  output  1  RAM write enable.
- ram_oe  output  1  RAM output enable.
- ram_address  output  ADDR_WIDTH  RAM address.
- ram_data_out  output  DATA_WIDTH  write data toward the RAM data pin.
- ram_data_drive  output  1  tristate enable for ram_data_out; high only during WR.
- ram_data_in  input  DATA_WIDTH  sampled RAM data pin.

Behaviour:
- Reset, asynchronous and immediate, including mid-transaction:
  - state = IDLE, rr_ptr = 0.
  - ack = 0, busy = 0, ram_cs = ram_we = ram_oe = ram_data_drive = 0.
  - ram_address = 0, ram_data_out = 0.
  - An interrupted op is abandoned with no ack; requesters reissue it.
- States: IDLE, WR, RD1, RD2.
- IDLE:
  - If req != 0, pick the winner: first set bit searching upward from rr_ptr, wrapping 3 to 0.
  - Latch owner, address, we and wdata.
  - Go to WR if req_we[owner] = 1, else to RD1.
  - Update rr_ptr = (owner+1) mod 4 at grant.
  - If req = 0, stay in IDLE.
- RAM control outputs are registered and loaded on state entry:
  - WR: cs = 1, we = 1, oe = 0, drive = 1.
  - RD1 and RD2: cs = 1, we = 0, oe = 1, drive = 0.
  - IDLE: all 0; address and data_out hold their last value.
- WR lasts 1 cycle:
  - RAM writes on the rising edge that ends WR.
  - ack[owner] = 1 during WR; next state IDLE.
- RD1 lasts 1 cycle:
  - The RAM registers its read data on the edge ending RD1.
  - Next state RD2.
- RD2 lasts 1 cycle:
  - Controls stay asserted so the RAM keeps driving its data pin.
  - rdata = ram_data_in, combinational pass-through.
  - ack[owner] = 1; the requester samples rdata on the edge ending RD2.
  - Next state IDLE.
- ack is decoded only from the state and owner registers. It is never combinational from req.
- Latency from the req-sampled IDLE edge:
  - Write: ack in the next cycle, 2 cycles per write.
  - Read: ack 2 cycles later, 3 cycles per read.
- Requester rules:
  - A requester that keeps req high after ack is treated as issuing a new transaction.
  - It is re-arbitrated in the following IDLE cycle.
  - Changing req_addr, req_we or req_wdata while req is high and before ack has no effect after the grant (values are latched).
- Fairness: with all four requesting continuously, grants rotate 0,1,2,3,0,...
  - No requester waits more than 3 other transactions.
- Outside ack, rdata = 0.
- ack is never multi-hot.

Test Plan:
- Reset mid-transaction: assert reset_n = 0 during RD1 -> all ram_* controls 0 and busy 0 at once; no ack; after release, grant order restarts at requester 0.
- Single write: req[2] = 1, we = 1, addr = 8'h3C, wdata = 8'hA5 -> WR cycle shows cs = we = drive = 1, ram_address = 3C, ram_data_out = A5; ack = 4'b0100 for 1 cycle; readback of 3C returns A5.
- Single read: RAM preloaded mem[8'h10] = 8'h5A; req[1] read of 10 -> ack = 4'b0010 exactly 2 cycles after grant; rdata = 5A in that cycle; ram_data_drive stays 0.
- Round-robin: all req held high, writes to addr = i -> ack sequence 0,1,2,3,0,1 at 2-cycle spacing; no ack ever multi-hot.
- Pointer fairness: after a grant to 3, req = 4'b1001 -> next grant 0, then 3.
- Back-to-back mixed ops: requester 0 writes FF to 8'h00, then requester 0 reads 8'h00 with req held -> rdata = FF; busy drops to 0 for exactly 1 IDLE cycle between ops.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - requester-side bus of the four-way RAM port arbiter
interface ram_port_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic [3:0]              req;
  logic [3:0]              req_we;
  logic [4*ADDR_WIDTH-1:0] req_addr;
  logic [4*DATA_WIDTH-1:0] req_wdata;
  logic [3:0]              ack;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    busy;

  modport master (
    output req, req_we, req_addr, req_wdata,
    input  ack, rdata, busy
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata,
    output ack, rdata, busy
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin arbiter sharing one synchronous RAM port among four requesters
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  ram_port_arbiter_if.slave     bus,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  ram_data_drive,
  input  logic [DATA_WIDTH-1:0] ram_data_in
);

  typedef enum logic [1:0] {IDLE, WR, RD1, RD2} state_t;

  state_t                state;
  state_t                next_state;
  logic [1:0]            rr_ptr;
  logic [1:0]            owner;
  logic [1:0]            winner;
  logic [1:0]            cand;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // Winner is the first requesting index at or after rr_ptr; scanning from the
  // farthest offset down lets the nearest one overwrite the result.
  always_comb begin
    winner = rr_ptr;
    cand   = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      cand = rr_ptr + 2'(k);
      if (bus.req[cand]) winner = cand;
    end
  end

  // Mux the winner's op, address and write data out of the packed buses.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (winner == 2'(i)) begin
        sel_we    = bus.req_we[i];
        sel_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // State register, plus owner and round-robin pointer captured at grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      owner  <= 2'd0;
      rr_ptr <= 2'd0;
    end else begin
      state <= next_state;
      if (state == IDLE && bus.req != 4'b0000) begin
        owner  <= winner;
        rr_ptr <= winner + 2'd1;
      end
    end
  end

  // Next-state decode: writes take one cycle, reads two.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.req != 4'b0000) next_state = sel_we ? WR : RD1;
      end
      WR:      next_state = IDLE;
      RD1:     next_state = RD2;
      RD2:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // RAM controls are registered and loaded from the state being entered, so
  // the pins are glitch-free; address and write data hold through IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_cs         <= 1'b0;
      ram_we         <= 1'b0;
      ram_oe         <= 1'b0;
      ram_data_drive <= 1'b0;
      ram_address    <= '0;
      ram_data_out   <= '0;
    end else begin
      case (next_state)
        WR: begin
          ram_cs         <= 1'b1;
          ram_we         <= 1'b1;
          ram_oe         <= 1'b0;
          ram_data_drive <= 1'b1;
          ram_address    <= sel_addr;
          ram_data_out   <= sel_wdata;
        end
        RD1: begin
          ram_cs         <= 1'b1;
          ram_we         <= 1'b0;
          ram_oe         <= 1'b1;
          ram_data_drive <= 1'b0;
          ram_address    <= sel_addr;
        end
        RD2: begin
          ram_cs         <= 1'b1;
          ram_we         <= 1'b0;
          ram_oe         <= 1'b1;
          ram_data_drive <= 1'b0;
        end
        default: begin
          ram_cs         <= 1'b0;
          ram_we         <= 1'b0;
          ram_oe         <= 1'b0;
          ram_data_drive <= 1'b0;
        end
      endcase
    end
  end

  // Requester-facing outputs decode from state and owner only, never from req.
  always_comb begin
    bus.ack   = 4'b0000;
    bus.rdata = '0;
    bus.busy  = (state != IDLE);
    if (state == WR || state == RD2) bus.ack[owner] = 1'b1;
    if (state == RD2) bus.rdata = ram_data_in;
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - self-checking bench for ram_port_arbiter with a synchronous RAM model
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ram_cs;
  logic       ram_we;
  logic       ram_oe;
  logic [7:0] ram_address;
  logic [7:0] ram_data_out;
  logic       ram_data_drive;
  logic [7:0] ram_data_in;

  ram_port_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

  ram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (bus.slave),
    .ram_cs         (ram_cs),
    .ram_we         (ram_we),
    .ram_oe         (ram_oe),
    .ram_address    (ram_address),
    .ram_data_out   (ram_data_out),
    .ram_data_drive (ram_data_drive),
    .ram_data_in    (ram_data_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM: writes on cs&we, registers read data on cs&oe,
  // drives its pin only while oe is high.
  logic [7:0] mem [256];
  logic [7:0] rd_reg = 8'h00;
  always @(posedge clk) begin
    if (!reset_n) mem[8'h10] <= 8'h5A;
    if (ram_cs && ram_we) mem[ram_address] <= ram_data_out;
    if (ram_cs && ram_oe) rd_reg <= mem[ram_address];
  end
  assign ram_data_in = ram_oe ? rd_reg : 8'h00;

  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] ack;
    bit         rd;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         cyc;
  } sb_t;

  sb_t exp_q[$];
  sb_t cur;

  task automatic push(input int i, input bit we, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] r, input int c);
    sb_t e;
    e.ack   = 4'b0001 << i;
    e.rd    = !we;
    e.addr  = a;
    e.wdata = d;
    e.rdata = r;
    e.cyc   = c;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every ack pops one expected completion.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.ack != 4'b0000) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 64'(bus.ack), 64'h0);
        end else begin
          cur = exp_q.pop_front();
          check("ack_onehot", 64'($onehot(bus.ack)), 64'h1);
          check("ack_owner", 64'(bus.ack), 64'(cur.ack));
          check("ack_cycle", 64'(cyc), 64'(cur.cyc));
          if (cur.rd) begin
            check("rd_ctrl", 64'({ram_cs, ram_we, ram_oe, ram_data_drive, ram_address}),
                  64'({4'b1010, cur.addr}));
            check("rdata", 64'(bus.rdata), 64'(cur.rdata));
          end else begin
            check("wr_ctrl", 64'({ram_cs, ram_we, ram_oe, ram_data_drive, ram_address, ram_data_out}),
                  64'({4'b1101, cur.addr, cur.wdata}));
          end
        end
      end else begin
        check("rdata_idle_zero", 64'(bus.rdata), 64'h0);
      end
    end
  end

  // Waits for n acks; either drops each acked requester or drops all at the last.
  task automatic run_until(input int n_acks, input bit drop_each);
    int seen = 0;
    for (int c = 0; c < 60 && seen < n_acks; c++) begin
      @(negedge clk);
      if (bus.ack != 4'b0000) begin
        seen++;
        if (drop_each) bus.req = bus.req & ~bus.ack;
        if (seen == n_acks) bus.req = 4'b0000;
      end
    end
    if (seen < n_acks) begin
      check("ack_timeout", 64'(seen), 64'(n_acks));
      bus.req = 4'b0000;
    end
  endtask

  task automatic drive(input int i, input bit we, input logic [7:0] a, input logic [7:0] d);
    bus.req_we[i]             = we;
    bus.req_addr[i*8 +: 8]    = a;
    bus.req_wdata[i*8 +: 8]   = d;
  endtask

  // One transaction from idle; for reads the request fields are scrambled
  // after the grant to show they were latched.
  task automatic single(input int i, input bit we, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] r);
    @(negedge clk);
    drive(i, we, a, d);
    bus.req[i] = 1'b1;
    push(i, we, a, d, r, cyc + (we ? 1 : 2));
    if (!we) begin
      @(negedge clk);
      drive(i, 1'b1, ~a, ~d);
    end
    run_until(1, 1'b1);
  endtask

  typedef struct {
    int         idx;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n;
    vecs[0] = '{2, 1'b1, 8'h3C, 8'hA5, 8'h00};
    vecs[1] = '{2, 1'b0, 8'h3C, 8'h00, 8'hA5};
    vecs[2] = '{1, 1'b0, 8'h10, 8'h00, 8'h5A};
    vecs[3] = '{0, 1'b1, 8'h55, 8'h0F, 8'h00};
    vecs[4] = '{0, 1'b0, 8'h55, 8'h00, 8'h0F};
    vecs[5] = '{3, 1'b1, 8'h80, 8'hC3, 8'h00};
    vecs[6] = '{3, 1'b0, 8'h80, 8'h00, 8'hC3};

    reset_n       = 1'b0;
    bus.req       = 4'b0000;
    bus.req_we    = 4'b0000;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", 64'({ram_cs, ram_we, ram_oe, ram_data_drive, bus.busy}), 64'h0);
    check("reset_ack", 64'(bus.ack), 64'h0);
    check("reset_addr_data", 64'({ram_address, ram_data_out}), 64'h0);
    reset_n = 1'b1;

    foreach (vecs[k])
      single(vecs[k].idx, vecs[k].we, vecs[k].addr, vecs[k].wdata, vecs[k].exp_rdata);

    // Pointer fairness: after a grant to 3, req=1001 grants 0 then 3.
    single(3, 1'b1, 8'h40, 8'h11, 8'h00);
    @(negedge clk);
    n = cyc;
    drive(0, 1'b1, 8'h41, 8'h22);
    drive(3, 1'b1, 8'h42, 8'h33);
    bus.req = 4'b1001;
    push(0, 1'b1, 8'h41, 8'h22, 8'h00, n + 1);
    push(3, 1'b1, 8'h42, 8'h33, 8'h00, n + 3);
    run_until(2, 1'b1);

    // Back-to-back: write FF to 00, then read it back with req held.
    @(negedge clk);
    n = cyc;
    drive(0, 1'b1, 8'h00, 8'hFF);
    bus.req[0] = 1'b1;
    push(0, 1'b1, 8'h00, 8'hFF, 8'h00, n + 1);
    push(0, 1'b0, 8'h00, 8'h00, 8'hFF, n + 4);
    @(negedge clk);
    check("b2b_busy_wr", 64'(bus.busy), 64'h1);
    bus.req_we[0] = 1'b0;
    @(negedge clk);
    check("b2b_busy_idle", 64'(bus.busy), 64'h0);
    @(negedge clk);
    check("b2b_busy_rd1", 64'(bus.busy), 64'h1);
    @(negedge clk);
    bus.req = 4'b0000;
    @(negedge clk);

    // Reset during RD1 of a read by requester 2 (leaves rr_ptr at 3 beforehand).
    @(negedge clk);
    drive(2, 1'b0, 8'h10, 8'h00);
    bus.req[2] = 1'b1;
    @(negedge clk);
    check("rd1_oe_before_reset", 64'({ram_cs, ram_oe}), 64'h3);
    reset_n = 1'b0;
    bus.req = 4'b0000;
    #1;
    check("midreset_ctrl", 64'({ram_cs, ram_we, ram_oe, ram_data_drive, bus.busy}), 64'h0);
    check("midreset_ack", 64'(bus.ack), 64'h0);
    check("midreset_addr_data", 64'({ram_address, ram_data_out}), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Round-robin with all four requesting; order must restart at 0.
    @(negedge clk);
    n = cyc;
    for (int i = 0; i < 4; i++) drive(i, 1'b1, 8'(i), 8'hB0 + 8'(i));
    bus.req = 4'b1111;
    for (int k = 0; k < 6; k++)
      push(k % 4, 1'b1, 8'(k % 4), 8'hB0 + 8'(k % 4), 8'h00, n + 1 + 2*k);
    run_until(6, 1'b0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++)
      check("rr_mem", 64'(mem[i]), 64'(8'hB0 + 8'(i)));
    check("mem_3C", 64'(mem[8'h3C]), 64'hA5);
    check("sb_drained", 64'(exp_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
